// File: rtl/letter_seq_pkg.sv
// Shared definitions for the letter sequencer: FSM state encoding and the blank glyph index.
package letter_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    GAP   = 2'd2,
    PAUSE = 2'd3
  } seq_state_e;

  localparam logic [3:0] IDX_BLANK = 4'd0;

endpackage

// File: rtl/letter_sequencer_if.sv
// Control/status bundle between a sequencer driver and letter_sequencer.
// The dir signal exists only when LETTER_SEQ_REVERSE_EN is defined.
interface letter_sequencer_if;
  logic       ena;
  logic       start;
  logic       stop;
  logic [1:0] speed;
`ifdef LETTER_SEQ_REVERSE_EN
  logic       dir;
`endif
  logic [3:0] counter;
  logic       busy;
  logic       wrap;

`ifdef LETTER_SEQ_REVERSE_EN
  modport master (output ena, start, stop, speed, dir, input counter, busy, wrap);
  modport slave  (input ena, start, stop, speed, dir, output counter, busy, wrap);
`else
  modport master (output ena, start, stop, speed, input counter, busy, wrap);
  modport slave  (input ena, start, stop, speed, output counter, busy, wrap);
`endif
endinterface

// File: rtl/letter_sequencer_tick_prescaler.sv
// Step-rate prescaler: one-cycle tick every max(PRESCALE>>speed,1) cycles while run is high.
module tick_prescaler #(
  parameter int unsigned PRESCALE = 10_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [1:0] speed,
  output logic       tick
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] term;
  logic [31:0]   period;

  // >= rather than == so a speed-up past the current count fires immediately
  always_comb begin
    period = 32'(PRESCALE) >> speed;
    if (period == 32'd0) period = 32'd1;
    term  = PW'(period - 32'd1);
    tick  = run && (cnt_q >= term);
    cnt_d = cnt_q;
    if (run) cnt_d = tick ? '0 : cnt_q + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/letter_sequencer.sv
// Glyph index sequencer feeding the seg7 letter decoder: FIRST_IDX..LAST_IDX, blank gap, repeat.
// Define LETTER_SEQ_REVERSE_EN to add the dir input (reverse order, sampled per repetition).
module letter_sequencer
  import letter_seq_pkg::*;
#(
  parameter int unsigned PRESCALE  = 10_000_000,
  parameter logic [3:0]  FIRST_IDX = 4'd1,
  parameter logic [3:0]  LAST_IDX  = 4'd7,
  parameter int unsigned GAP_TICKS = 2
) (
  input logic               clk,
  input logic               rst_n,
  letter_sequencer_if.slave bus
);

  localparam int unsigned GW       = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_TICKS - 1);

  seq_state_e    state_q, state_d;
  logic [3:0]    counter_q, counter_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          wrap_q, wrap_d;
  logic          tick, run;
  logic [3:0]    start_glyph, end_glyph, next_glyph;

  // stop gates the prescaler so the cycle that enters PAUSE leaves it untouched
  assign run = bus.ena && !bus.stop && (state_q == RUN || state_q == GAP);

  tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run),
    .speed (bus.speed),
    .tick  (tick)
  );

`ifdef LETTER_SEQ_REVERSE_EN
  logic rev_q, rev_d;

  // direction is latched whenever a repetition starts, i.e. exactly when wrap_d is set
  always_comb begin
    rev_d       = wrap_d ? bus.dir : rev_q;
    start_glyph = bus.dir ? LAST_IDX : FIRST_IDX;
    end_glyph   = rev_q ? FIRST_IDX : LAST_IDX;
    next_glyph  = rev_q ? counter_q - 4'd1 : counter_q + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rev_q <= 1'b0;
    else        rev_q <= rev_d;
  end
`else
  always_comb begin
    start_glyph = FIRST_IDX;
    end_glyph   = LAST_IDX;
    next_glyph  = counter_q + 4'd1;
  end
`endif

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    gap_d     = gap_q;
    wrap_d    = 1'b0;
    if (bus.ena) begin
      unique case (state_q)
        IDLE: begin
          if (bus.start && !bus.stop) begin
            state_d   = RUN;
            counter_d = start_glyph;
            wrap_d    = 1'b1;
          end
        end
        RUN: begin
          if (bus.stop) begin
            state_d = PAUSE;
          end else if (tick) begin
            if (counter_q == end_glyph) begin
              state_d   = GAP;
              counter_d = IDX_BLANK;
              gap_d     = '0;
            end else begin
              counter_d = next_glyph;
            end
          end
        end
        GAP: begin
          if (bus.stop) begin
            state_d = PAUSE;
          end else if (tick) begin
            if (gap_q == GAP_LAST) begin
              state_d   = RUN;
              counter_d = start_glyph;
              wrap_d    = 1'b1;
            end else begin
              gap_d = gap_q + GW'(1);
            end
          end
        end
        PAUSE: begin
          if (bus.start && !bus.stop)
            state_d = (counter_q != IDX_BLANK) ? RUN : GAP;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      counter_q <= IDX_BLANK;
      gap_q     <= '0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      gap_q     <= gap_d;
      wrap_q    <= wrap_d;
    end
  end

  assign bus.counter = counter_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.wrap    = wrap_q && bus.ena;

endmodule

// File: tb/tb_letter_sequencer.sv
// Scoreboard bench for letter_sequencer (PRESCALE=8, GAP_TICKS=2): expected output segments are queued
// with their durations; a negedge monitor pops one entry each time (counter, wrap) changes.
module tb_letter_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  letter_sequencer_if b ();

  letter_sequencer #(.PRESCALE(8), .GAP_TICKS(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] cnt;
    logic       wrap;
    int         dur;   // expected segment length in cycles, 0 = unchecked
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  logic mon_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", nm, got, want, $time);
    end
  endtask

  task automatic push(input logic [3:0] c, input logic w, input int d);
    exp_t e;
    e.cnt  = c;
    e.wrap = w;
    e.dur  = d;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // monitor
  logic [3:0] prev_cnt = 4'd0;
  logic       prev_wrap = 1'b0;
  int         run_len = 0;
  int         seg_exp = 0;

  always @(negedge clk) begin
    if (mon_on) begin
      if (b.counter !== prev_cnt || b.wrap !== prev_wrap) begin
        if (seg_exp != 0) chk("seg_len", 32'(run_len), 32'(seg_exp));
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output got cnt=%0d wrap=%0d want none at %0t", b.counter, b.wrap, $time);
          seg_exp = 0;
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("glyph", 32'(b.counter), 32'(e.cnt));
          chk("wrap", 32'(b.wrap), 32'(e.wrap));
          seg_exp = e.dur;
        end
        run_len = 1;
      end else begin
        run_len++;
      end
      prev_cnt  = b.counter;
      prev_wrap = b.wrap;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    b.ena   = 1'b1;
    b.start = 1'b0;
    b.stop  = 1'b0;
    b.speed = 2'd0;
`ifdef LETTER_SEQ_REVERSE_EN
    b.dir   = 1'b0;
`endif
    step(2);
    chk("rst_counter", 32'(b.counter), 0);
    chk("rst_busy", 32'(b.busy), 0);
    chk("rst_wrap", 32'(b.wrap), 0);
    rst_n  = 1'b1;
    mon_on = 1'b1;

    // start and stop together in IDLE: stop wins
    b.start = 1'b1;
    b.stop  = 1'b1;
    step(3);
    chk("idle_prio_counter", 32'(b.counter), 0);
    chk("idle_prio_busy", 32'(b.busy), 0);

    // full cycle at speed 0
    b.stop = 1'b0;
    push(4'd1, 1'b1, 1);
    push(4'd1, 1'b0, 7);
    for (int g = 2; g <= 7; g++) push(4'(g), 1'b0, 8);
    push(4'd0, 1'b0, 16);
    push(4'd1, 1'b1, 1);
    step(1);
    b.start = 1'b0;
    chk("run_busy", 32'(b.busy), 1);
    step(60);
    chk("gap_counter", 32'(b.counter), 0);
    chk("gap_busy", 32'(b.busy), 1);
    step(12);

    // speed 1: four cycles per glyph
    b.speed = 2'd1;
    push(4'd1, 1'b0, 3);
    for (int g = 2; g <= 7; g++) push(4'(g), 1'b0, 4);
    push(4'd0, 1'b0, 8);
    push(4'd1, 1'b1, 1);
    step(36);

    // speed 3: one cycle per glyph
    b.speed = 2'd3;
    for (int g = 2; g <= 7; g++) push(4'(g), 1'b0, 1);
    push(4'd0, 1'b0, 2);
    push(4'd1, 1'b1, 1);
    step(9);

    // pause at glyph 4, three cycles into its period
    b.speed = 2'd0;
    push(4'd1, 1'b0, 7);
    push(4'd2, 1'b0, 8);
    push(4'd3, 1'b0, 8);
    push(4'd4, 1'b0, 29);
    for (int g = 5; g <= 7; g++) push(4'(g), 1'b0, 8);
    push(4'd0, 1'b0, 16);
    push(4'd1, 1'b1, 1);
    step(27);
    b.stop = 1'b1;
    step(10);
    b.start = 1'b1;
    step(9);
    chk("pause_counter", 32'(b.counter), 4);
    chk("pause_busy", 32'(b.busy), 1);
    step(1);
    b.stop = 1'b0;
    step(1);
    b.start = 1'b0;
    step(4);
    chk("resume_hold", 32'(b.counter), 4);
    step(1);
    chk("resume_step", 32'(b.counter), 5);
    step(40);

    // ena low for 10 cycles inside glyph 1's period
    push(4'd1, 1'b0, 17);
    push(4'd2, 1'b0, 0);
    push(4'd0, 1'b0, 0);
    step(3);
    b.ena = 1'b0;
    step(5);
    chk("ena_counter", 32'(b.counter), 1);
    chk("ena_wrap", 32'(b.wrap), 0);
    step(5);
    b.ena = 1'b1;
    step(7);

    // asynchronous reset in the middle of a cycle
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_counter", 32'(b.counter), 0);
    chk("async_rst_busy", 32'(b.busy), 0);
    chk("async_rst_wrap", 32'(b.wrap), 0);
    step(2);
    rst_n = 1'b1;

`ifdef LETTER_SEQ_REVERSE_EN
    // reverse message, dir flipped mid-message applies after the gap
    b.dir   = 1'b1;
    b.speed = 2'd3;
    b.start = 1'b1;
    push(4'd7, 1'b1, 1);
    for (int g = 6; g >= 1; g--) push(4'(g), 1'b0, 1);
    push(4'd0, 1'b0, 2);
    push(4'd1, 1'b1, 1);
    for (int g = 2; g <= 7; g++) push(4'(g), 1'b0, 1);
    push(4'd0, 1'b0, 2);
    push(4'd1, 1'b1, 1);
    push(4'd1, 1'b0, 0);
    step(1);
    b.start = 1'b0;
    step(2);
    b.dir = 1'b0;
    step(16);
    b.stop = 1'b1;
    step(3);
    chk("rev_stop_hold", 32'(b.counter), 1);
`endif

    step(5);
    chk("sb_drained", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
